// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-memory read engines: address width, memory word size, read FSM states.
package mm_pkg;

    localparam int ADDR_W         = 16;
    localparam int MEM_WORD_BYTES = 32;
    localparam int MEM_DATA_W     = MEM_WORD_BYTES * 8;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } rd_state_e;

    // Counter wide enough to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_b_read_engine_if.sv
// Bus bundle of the B read engine: address FIFO head, memory B req/gnt/rdata port, and output data stream.
interface mem_b_read_engine_if #(
    parameter int DATA_W = mm_pkg::MEM_DATA_W
) ();

    logic [mm_pkg::ADDR_W-1:0] addr_fifo_data;
    logic                      addr_fifo_empty;
    logic                      addr_fifo_pop;
    logic                      mem_req;
    logic [mm_pkg::ADDR_W-1:0] mem_addr;
    logic                      mem_gnt;
    logic                      mem_rvalid;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      b_data_valid;
    logic [DATA_W-1:0]         b_data;
    logic                      b_data_ready;

    modport master (
        input  addr_fifo_data, addr_fifo_empty, mem_gnt, mem_rvalid, mem_rdata, b_data_ready,
        output addr_fifo_pop, mem_req, mem_addr, b_data_valid, b_data
    );

    modport slave (
        output addr_fifo_data, addr_fifo_empty, mem_gnt, mem_rvalid, mem_rdata, b_data_ready,
        input  addr_fifo_pop, mem_req, mem_addr, b_data_valid, b_data
    );

endinterface

// File: rtl/mem_b_rdata_buf.sv
// Circular first-word-fall-through return buffer with occupancy count; shared by the A and B read engines.
module mem_b_rdata_buf
    import mm_pkg::*;
#(
    parameter  int DATA_W = MEM_DATA_W,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_ok;
    logic              rd_ok;

    assign rd_ok = rd_en && (count_q != '0);
    // A write into a full buffer is only accepted if a read frees a slot in the same cycle.
    assign wr_ok = wr_en && ((count_q != FULL) || rd_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/mem_b_read_engine.sv
// B-matrix read engine: pops addresses, issues credit-limited reads to memory B, streams returned words in order.
// Optional stall counters are enabled with the MEM_B_RD_PERF_CNT_EN macro.
module mem_b_read_engine
    import mm_pkg::*;
#(
    parameter int MEM_DATA_WIDTH_BYTES = MEM_WORD_BYTES,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_b_read_engine_if.master  bus,
    output logic                 busy
`ifdef MEM_B_RD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_credit_cnt,
    output logic [31:0]          stall_gnt_cnt
`endif
);

    localparam int DW    = MEM_DATA_WIDTH_BYTES * 8;
    localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] MAX_CRED = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    rd_state_e         state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              run_q;
    logic              pop;
    logic              issue;
    logic              ret_ok;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W-1:0]  occupied;
    logic [CNT_W-1:0]  credits;

    assign occupied = inflight_q + buf_count;
    assign credits  = MAX_CRED - occupied;
    assign issue    = mem_req_q && bus.mem_gnt;
    // Returns with nothing in flight (e.g. stragglers from before a reset) are dropped.
    assign ret_ok   = bus.mem_rvalid && (inflight_q != '0);

    // The request being granted is not yet in inflight, so a follow-on pop needs a second free credit.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_q && !bus.addr_fifo_empty && (credits != '0)) begin
                    pop        = 1'b1;
                    mem_addr_d = bus.addr_fifo_data;
                    mem_req_d  = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    if (!bus.addr_fifo_empty && (credits > ONE)) begin
                        pop        = 1'b1;
                        mem_addr_d = bus.addr_fifo_data;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_comb begin
        case ({issue, ret_ok})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // run_q holds off popping for the first cycle after reset so pop is low throughout reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            inflight_q <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            inflight_q <= inflight_d;
            run_q      <= 1'b1;
        end
    end

    mem_b_rdata_buf #(
        .DATA_W (DW),
        .DEPTH  (MAX_OUTSTANDING)
    ) u_rdata_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (ret_ok),
        .wr_data  (bus.mem_rdata),
        .rd_en    (bus.b_data_ready),
        .rd_valid (bus.b_data_valid),
        .rd_data  (bus.b_data),
        .count    (buf_count)
    );

    assign bus.addr_fifo_pop = pop;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_addr      = mem_addr_q;
    assign busy              = mem_req_q || (inflight_q != '0) || (buf_count != '0);

`ifdef MEM_B_RD_PERF_CNT_EN
    logic [31:0] stall_credit_cnt_q, stall_credit_cnt_d;
    logic [31:0] stall_gnt_cnt_q, stall_gnt_cnt_d;

    always_comb begin
        stall_credit_cnt_d = stall_credit_cnt_q;
        stall_gnt_cnt_d    = stall_gnt_cnt_q;
        if (!bus.addr_fifo_empty && (credits == '0) && (stall_credit_cnt_q != '1)) begin
            stall_credit_cnt_d = stall_credit_cnt_q + 32'd1;
        end
        if (mem_req_q && !bus.mem_gnt && (stall_gnt_cnt_q != '1)) begin
            stall_gnt_cnt_d = stall_gnt_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_credit_cnt_q <= '0;
            stall_gnt_cnt_q    <= '0;
        end else begin
            stall_credit_cnt_q <= stall_credit_cnt_d;
            stall_gnt_cnt_q    <= stall_gnt_cnt_d;
        end
    end

    assign stall_credit_cnt = stall_credit_cnt_q;
    assign stall_gnt_cnt    = stall_gnt_cnt_q;
`endif

endmodule

// File: tb/tb_mem_b_read_engine.sv
// Bench for mem_b_read_engine: queue-based FIFO/memory/consumer model with directed and random traffic.
`timescale 1ns/1ps
module tb_mem_b_read_engine;
    import mm_pkg::*;

    localparam int MAXO = 4;
    localparam int DW   = 256;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    mem_b_read_engine_if #(.DATA_W(DW)) bus ();

`ifdef MEM_B_RD_PERF_CNT_EN
    logic [31:0] stall_credit_cnt;
    logic [31:0] stall_gnt_cnt;
`endif

    mem_b_read_engine #(
        .MEM_DATA_WIDTH_BYTES (32),
        .MAX_OUTSTANDING      (MAXO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
`ifdef MEM_B_RD_PERF_CNT_EN
        ,
        .stall_credit_cnt (stall_credit_cnt),
        .stall_gnt_cnt    (stall_gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model state: FIFO contents, popped-not-granted addresses, expected stream, memory return pipe.
    logic [15:0]   fifo_q[$];
    logic [15:0]   issued_q[$];
    logic [DW-1:0] exp_q[$];
    int            ret_due[$];
    logic [DW-1:0] ret_data[$];
    int cyc = 0, last_due = 0;
    int granted = 0, consumed = 0, returned = 0;
    int pops_t = 0, grants_t = 0, req_cycles_t = 0;
    int gnt_pct = 100, rdy_pct = 100, lat_min = 2, lat_max = 2, gnt_block = 0;
    logic          prev_stall = 1'b0;
    logic [15:0]   prev_addr = '0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [15:0] a);
        return {8{a, a ^ 16'hA5C3}};
    endfunction

    task automatic step();
        logic        rv;
        int          buf_now, lat, due;
        logic [15:0] ea;
        @(negedge clk);
        bus.addr_fifo_empty = (fifo_q.size() == 0);
        bus.addr_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0;
        bus.mem_gnt         = (gnt_block > 0) ? 1'b0 : ($urandom_range(99) < gnt_pct);
        rv                  = (ret_due.size() != 0) && (ret_due[0] <= cyc);
        bus.mem_rvalid      = rv;
        bus.mem_rdata       = rv ? ret_data[0] : {8{$urandom()}};
        bus.b_data_ready    = ($urandom_range(99) < rdy_pct);
        #1;
        buf_now = returned - consumed;
        if (prev_stall) begin
            check_val("req_hold", bus.mem_req, 1'b1);
            check_val("addr_hold", bus.mem_addr, prev_addr);
        end
        check_val("valid", bus.b_data_valid, buf_now > 0);
        if (granted != consumed) check_val("busy_active", busy, 1'b1);
        if (rv) check_val("no_overflow", buf_now != MAXO, 1'b1);
        if (bus.mem_req) req_cycles_t++;
        if (bus.b_data_valid && bus.b_data_ready) begin
            if (exp_q.size() == 0) check_val("beat_unexpected", 1'b1, 1'b0);
            else check_val("data", bus.b_data, exp_q.pop_front());
            consumed++;
        end
        if (bus.addr_fifo_pop) begin
            pops_t++;
            if (fifo_q.size() == 0) check_val("pop_empty", 1'b1, 1'b0);
            else issued_q.push_back(fifo_q.pop_front());
        end
        if (bus.mem_req && bus.mem_gnt) begin
            grants_t++;
            granted++;
            if (issued_q.size() == 0) begin
                check_val("gnt_unpopped", 1'b1, 1'b0);
            end else begin
                ea = issued_q.pop_front();
                check_val("mem_addr", bus.mem_addr, ea);
                check_val("credit_limit", (granted - consumed) <= MAXO, 1'b1);
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                ret_due.push_back(due);
                ret_data.push_back(data_of(ea));
                exp_q.push_back(data_of(ea));
            end
        end
        if (rv) begin
            void'(ret_due.pop_front());
            void'(ret_data.pop_front());
            returned++;
        end
        prev_stall = bus.mem_req && !bus.mem_gnt;
        prev_addr  = bus.mem_addr;
        if (gnt_block > 0) gnt_block--;
        cyc++;
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n = 0;
        while (consumed < target && n < budget) begin
            step();
            n++;
        end
        if (consumed < target) check_val({tag, "_timeout"}, consumed, target);
        n = 0;
        while (busy && n < 30) begin
            step();
            n++;
        end
        check_val({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic clear_t();
        pops_t = 0; grants_t = 0; req_cycles_t = 0;
    endtask

    initial begin
        bus.addr_fifo_empty = 1'b1;
        bus.addr_fifo_data  = '0;
        bus.mem_gnt         = 1'b0;
        bus.mem_rvalid      = 1'b0;
        bus.mem_rdata       = '0;
        bus.b_data_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pop", bus.addr_fifo_pop, 1'b0);
        check_val("rst_req", bus.mem_req, 1'b0);
        check_val("rst_addr", bus.mem_addr, 16'h0);
        check_val("rst_valid", bus.b_data_valid, 1'b0);
        check_val("rst_data", bus.b_data, '0);
        check_val("rst_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // single read
        clear_t();
        fifo_q.push_back(16'h0040);
        gnt_pct = 100; rdy_pct = 100; lat_min = 2; lat_max = 2;
        run_until("single", consumed + 1, 20);
        check_val("single_pops", pops_t, 1);
        check_val("single_grants", grants_t, 1);

        // back-to-back
        clear_t();
        for (int i = 0; i < 8; i++) fifo_q.push_back(16'h0100 + 16'(i * 4));
        lat_min = 3; lat_max = 3;
        run_until("b2b", consumed + 8, 40);
        check_val("b2b_pops", pops_t, 8);

        // credit stall
        clear_t();
        for (int i = 0; i < 10; i++) fifo_q.push_back(16'h2000 + 16'(i));
        rdy_pct = 0; lat_min = 2; lat_max = 2;
        repeat (30) step();
        check_val("credit_pops", pops_t, MAXO);
        check_val("credit_grants", grants_t, MAXO);
        check_val("credit_req_low", bus.mem_req, 1'b0);
        check_val("credit_full", bus.b_data_valid, 1'b1);
        rdy_pct = 100;
        run_until("credit_release", consumed + 10, 60);
        check_val("credit_total_pops", pops_t, 10);

        // grant stall
        clear_t();
        fifo_q.push_back(16'h3333);
        gnt_block = 6;
        run_until("gnt_stall", consumed + 1, 30);
        check_val("gnt_stall_req_cycles", req_cycles_t, 6);
        check_val("gnt_stall_pops", pops_t, 1);

        // concurrent write/read with a full buffer
        clear_t();
        for (int i = 0; i < 12; i++) fifo_q.push_back(16'h4000 + 16'(i));
        rdy_pct = 0; lat_min = 1; lat_max = 1;
        repeat (12) step();
        rdy_pct = 100;
        run_until("simul", consumed + 12, 60);

        // random traffic
        clear_t();
        for (int i = 0; i < 60; i++) fifo_q.push_back(16'($urandom()));
        gnt_pct = 60; rdy_pct = 50; lat_min = 1; lat_max = 5;
        run_until("random", consumed + 60, 1500);
        check_val("random_pops", pops_t, 60);

        // reset mid-burst
        for (int i = 0; i < 6; i++) fifo_q.push_back(16'h5000 + 16'(i));
        gnt_pct = 100; rdy_pct = 0; lat_min = 5; lat_max = 5;
        begin
            int n = 0;
            while ((granted - returned) < 3 && n < 20) begin step(); n++; end
            check_val("rst_mid_inflight", (granted - returned) >= 3, 1'b1);
        end
        #1 reset_n = 1'b0;
        #1;
        check_val("rstm_pop", bus.addr_fifo_pop, 1'b0);
        check_val("rstm_req", bus.mem_req, 1'b0);
        check_val("rstm_addr", bus.mem_addr, 16'h0);
        check_val("rstm_valid", bus.b_data_valid, 1'b0);
        check_val("rstm_data", bus.b_data, '0);
        check_val("rstm_busy", busy, 1'b0);
        fifo_q.delete(); issued_q.delete(); exp_q.delete(); ret_due.delete(); ret_data.delete();
        granted = 0; consumed = 0; returned = 0; last_due = cyc; prev_stall = 1'b0;
        bus.addr_fifo_empty = 1'b1;
        bus.mem_gnt = 1'b0;
        bus.b_data_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = {8{32'hDEADBEEF}};
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        check_val("stray_valid", bus.b_data_valid, 1'b0);
        check_val("stray_busy", busy, 1'b0);

        // recovery after reset
        clear_t();
        fifo_q.push_back(16'h7777);
        rdy_pct = 100; lat_min = 2; lat_max = 4;
        run_until("recover", consumed + 1, 20);
        check_val("recover_pops", pops_t, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule
